// File: rtl/abro_sched_pkg.sv
// Shared definitions for the ABRO event scheduler: controller state
// encodings and the event-kind constants carried on req_kind.
package abro_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        RESTART = 2'b10,
        CLEAR   = 2'b11
    } sched_state_t;

    localparam logic KIND_A = 1'b0;
    localparam logic KIND_B = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Picks the first asserted request at or
// after the pointer, wrapping around, and reports it as a one-hot grant plus
// its binary index. A low enable suppresses every grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      pointer,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      grant_idx
);

    localparam int SW = PW + 1;

    logic          found;
    logic [SW-1:0] sum;
    logic [PW-1:0] idx;

    // Walk the requesters starting at the pointer and grant the first valid one
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, pointer} + SW'(k);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            idx = sum[PW-1:0];
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/abro_event_scheduler.sv
// Shares one ABRO state machine between several event requesters. Requests
// are granted round-robin and forwarded as single-cycle A/B pulses; once the
// machine signals O (or the watchdog expires) a restart pulse is issued and
// the scheduler waits for O to fall before taking new events.
module abro_event_scheduler
    import abro_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8,
    localparam int PW   = $clog2(NUM_REQ),
    localparam int WD_W = $clog2(TIMEOUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_kind,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               abro_A,
    output logic               abro_B,
    output logic               abro_R,
    input  logic               abro_O,
    output logic               done_pulse,
    output logic               timeout_pulse,
    output logic [CNT_W-1:0]   done_count,
    output logic               busy,
    output logic [1:0]         state
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [PW-1:0]   PTR_LAST = PW'(NUM_REQ - 1);

    sched_state_t        cur_state;
    logic [PW-1:0]       pointer;
    logic [WD_W-1:0]     watchdog;
    logic [NUM_REQ-1:0]  grant;
    logic [PW-1:0]       grant_idx;
    logic                grant_en;
    logic                transfer;

    assign grant_en  = ((cur_state == IDLE) || (cur_state == COLLECT)) && !abro_O;
    assign req_ready = grant;
    assign transfer  = |grant;
    assign state     = cur_state;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .pointer   (pointer),
        .enable    (grant_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Controller: state, pointer, watchdog, event/restart pulses and completion count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state     <= IDLE;
            busy          <= 1'b0;
            pointer       <= '0;
            watchdog      <= '0;
            done_count    <= '0;
            abro_A        <= 1'b0;
            abro_B        <= 1'b0;
            abro_R        <= 1'b0;
            done_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            abro_A        <= transfer && (req_kind[grant_idx] == KIND_A);
            abro_B        <= transfer && (req_kind[grant_idx] == KIND_B);
            abro_R        <= 1'b0;
            done_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;

            if (transfer) begin
                pointer <= (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
            end

            case (cur_state)
                IDLE: begin
                    if (transfer) begin
                        cur_state <= COLLECT;
                        busy      <= 1'b1;
                        watchdog  <= '0;
                    end
                end
                COLLECT: begin
                    if (abro_O) begin
                        done_pulse <= 1'b1;
                        abro_R     <= 1'b1;
                        cur_state  <= RESTART;
                        if (done_count != '1) begin
                            done_count <= done_count + 1'b1;
                        end
                    end else if (watchdog == WD_LAST) begin
                        timeout_pulse <= 1'b1;
                        abro_R        <= 1'b1;
                        cur_state     <= RESTART;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                RESTART: begin
                    cur_state <= CLEAR;
                end
                CLEAR: begin
                    if (!abro_O) begin
                        cur_state <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    cur_state <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abro_event_scheduler.sv
// Testbench for abro_event_scheduler. A behavioural ABRO machine drives
// abro_O from the scheduler's A/B/R pulses, and a phase-level reference
// model predicts grants and registered outputs every cycle.
module tb_abro_event_scheduler;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NUM_REQ-1:0] req_valid = '0;
    logic [NUM_REQ-1:0] req_kind = '0;
    logic [NUM_REQ-1:0] req_ready;
    logic               abro_A, abro_B, abro_R;
    logic               abro_O = 1'b0;
    logic               done_pulse, timeout_pulse;
    logic [CNT_W-1:0]   done_count;
    logic               busy;
    logic [1:0]         state;

    always #5 clk = ~clk;

    abro_event_scheduler #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_kind      (req_kind),
        .req_ready     (req_ready),
        .abro_A        (abro_A),
        .abro_B        (abro_B),
        .abro_R        (abro_R),
        .abro_O        (abro_O),
        .done_pulse    (done_pulse),
        .timeout_pulse (timeout_pulse),
        .done_count    (done_count),
        .busy          (busy),
        .state         (state)
    );

    int testsRun = 0;
    int testsFailed = 0;

    // reference model: phase 0 idle, 1 collecting, 2 restarting, 3 clearing
    int   mPhase, mPtr, mAge, mDone;
    logic eA, eB, eR, eD, eT;

    // ABRO machine and stimulus knobs
    logic        seenA, seenB;
    int          holdLeft, holdMax;
    bit          randHold, forceAtExpiry;
    int unsigned activeMask;
    int          validPct, fixedKind;

    int doneSeen, toSeen, rSeen, clearCycles;
    logic [NUM_REQ-1:0] lastReady;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int modelGrant(input int unsigned v, input logic o);
        if (o || mPhase > 1) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (mPtr + k) % NUM_REQ;
            if (((v >> i) & 1) != 0) return i;
        end
        return -1;
    endfunction

    task automatic modelStep(input int g);
        eA = 1'b0; eB = 1'b0; eR = 1'b0; eD = 1'b0; eT = 1'b0;
        if (g >= 0) begin
            if (((32'(req_kind) >> g) & 1) == 0) eA = 1'b1;
            else eB = 1'b1;
            mPtr = (g + 1) % NUM_REQ;
        end
        case (mPhase)
            0: if (g >= 0) begin mPhase = 1; mAge = 0; end
            1: begin
                if (abro_O) begin
                    eD = 1'b1; eR = 1'b1; mPhase = 2;
                    if (mDone < CNT_MAX) mDone++;
                end else begin
                    mAge++;
                    if (mAge == TIMEOUT) begin eT = 1'b1; eR = 1'b1; mPhase = 2; end
                end
            end
            2: mPhase = 3;
            default: if (!abro_O) mPhase = 0;
        endcase
    endtask

    // one clock cycle, entered and left at the falling edge
    task automatic runCycle();
        int g;
        int unsigned v, k;
        logic [NUM_REQ-1:0] expReady;
        checkOutput("abro_A", abro_A, eA);
        checkOutput("abro_B", abro_B, eB);
        checkOutput("abro_R", abro_R, eR);
        checkOutput("done_pulse", done_pulse, eD);
        checkOutput("timeout_pulse", timeout_pulse, eT);
        checkOutput("done_count", done_count, mDone);
        checkOutput("busy", busy, mPhase != 0);
        checkOutput("state", state, mPhase);
        if (done_pulse) doneSeen++;
        if (timeout_pulse) toSeen++;
        if (abro_R) rSeen++;
        if (state == 2'b11) clearCycles++;

        if (abro_R) begin
            seenA = 1'b0; seenB = 1'b0;
            holdLeft = randHold ? int'($urandom_range(0, 3)) : holdMax;
        end else if (holdLeft > 0) begin
            holdLeft--;
        end else begin
            if (abro_A) seenA = 1'b1;
            if (abro_B) seenB = 1'b1;
        end
        abro_O = (holdLeft > 0) || (seenA && seenB) ||
                 (forceAtExpiry && mPhase == 1 && mAge == TIMEOUT - 1);

        v = 0; k = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (((activeMask >> i) & 1) != 0 && $urandom_range(0, 99) < validPct) v |= (1 << i);
            if ((fixedKind < 0) ? ($urandom_range(0, 1) == 1) : (fixedKind == 1)) k |= (1 << i);
        end
        req_valid = NUM_REQ'(v);
        req_kind  = NUM_REQ'(k);

        #1;
        g = modelGrant(32'(req_valid), abro_O);
        expReady = (g >= 0) ? NUM_REQ'(1 << g) : '0;
        lastReady = req_ready;
        checkOutput("req_ready", req_ready, expReady);
        @(posedge clk);
        modelStep(g);
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        // one cycle of randomized traffic under the current stimulus knobs
        runCycle();
    endtask

    task automatic applyReset();
        #2;
        reset = 1'b0;
        req_valid = '0;
        abro_O = 1'b0;
        #1;
        checkOutput("rst_abro_A", abro_A, 0);
        checkOutput("rst_abro_B", abro_B, 0);
        checkOutput("rst_abro_R", abro_R, 0);
        checkOutput("rst_done", done_pulse, 0);
        checkOutput("rst_timeout", timeout_pulse, 0);
        checkOutput("rst_count", done_count, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_ready", req_ready, 0);
        mPhase = 0; mPtr = 0; mAge = 0; mDone = 0;
        eA = 0; eB = 0; eR = 0; eD = 0; eT = 0;
        seenA = 0; seenB = 0; holdLeft = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 40; n++) begin
            if (state == 2'b00) return;
            runCycle();
        end
        checkOutput("wait_idle", state, 0);
    endtask

    // requester 0 sends two events back to back, then others may request
    task automatic doSequence(input int k1, input int k2, input int unsigned idleMask);
        activeMask = 1; validPct = 100;
        fixedKind = k1;
        runCycle();
        checkOutput(k1 == 0 ? "seq_first_A" : "seq_first_B", k1 == 0 ? abro_A : abro_B, 1);
        fixedKind = k2;
        runCycle();
        checkOutput(k2 == 0 ? "seq_second_A" : "seq_second_B", k2 == 0 ? abro_A : abro_B, 1);
        activeMask = idleMask; fixedKind = 0;
        waitIdle();
    endtask

    int sat [5] = '{1, 2, 3, 3, 3};
    int order [5] = '{1, 2, 4, 8, 1};

    initial begin
        int n, cs;
        holdMax = 0; randHold = 0; forceAtExpiry = 0;
        activeMask = 0; validPct = 100; fixedKind = -1;
        @(negedge clk);
        applyReset();

        // A then B from requester 0 completes one sequence
        doneSeen = 0; rSeen = 0;
        doSequence(0, 1, 0);
        checkOutput("t1_done_seen", doneSeen, 1);
        checkOutput("t1_r_seen", rSeen, 1);
        checkOutput("t1_count", done_count, 1);
        checkOutput("t1_state", state, 0);

        // all requesters busy: strict rotation
        applyReset();
        activeMask = 4'hF; validPct = 100; fixedKind = 0;
        for (int i = 0; i < 5; i++) begin
            runCycle();
            checkOutput("rr_order", lastReady, order[i]);
            checkOutput("rr_onehot", $countones(lastReady), 1);
        end
        activeMask = 0;
        waitIdle();

        // requester 2 only sends A: watchdog restart
        applyReset();
        activeMask = 4; fixedKind = 0; cs = -1; n = 0;
        while (n < 30) begin
            if (state == 2'b01 && cs < 0) cs = n;
            if (timeout_pulse) break;
            runCycle();
            n++;
        end
        checkOutput("to_latency", n - cs, TIMEOUT);
        checkOutput("to_with_R", abro_R, 1);
        checkOutput("to_count", done_count, 0);
        activeMask = 0;
        waitIdle();

        // O arrives on the watchdog's last cycle: completion wins
        applyReset();
        activeMask = 4; fixedKind = 0; forceAtExpiry = 1;
        for (int i = 0; i < 30; i++) begin
            if (done_pulse) break;
            runCycle();
        end
        checkOutput("race_done", done_pulse, 1);
        checkOutput("race_timeout", timeout_pulse, 0);
        checkOutput("race_count", done_count, 1);
        forceAtExpiry = 0; activeMask = 0;
        waitIdle();

        // O held after restart keeps the scheduler in CLEAR with no grants
        applyReset();
        holdMax = 3; clearCycles = 0;
        doSequence(0, 1, 4'hE);
        checkOutput("clear_cycles", clearCycles, 3);
        holdMax = 0;

        // reset one cycle after a grant in COLLECT
        applyReset();
        activeMask = 4'hF; validPct = 100; fixedKind = 0;
        for (int i = 0; i < 10; i++) begin
            runCycle();
            if (mPhase == 1 && (abro_A || abro_B)) break;
        end
        checkOutput("pre_reset_pulse", abro_A, 1);
        applyReset();
        runCycle();
        checkOutput("ptr_restart", lastReady, 1);
        activeMask = 0;
        waitIdle();

        // saturating completion counter
        applyReset();
        for (int i = 0; i < 5; i++) begin
            doSequence(i % 2, (i + 1) % 2, 0);
            checkOutput("sat_count", done_count, sat[i]);
        end

        // randomized traffic
        randHold = 1;
        for (int blk = 0; blk < 20; blk++) begin
            activeMask = $urandom_range(0, 15);
            validPct = $urandom_range(20, 100);
            fixedKind = -1;
            forceAtExpiry = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < 100; c++) applyStimulus();
            if (blk % 5 == 4) applyReset();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, %0d failed so far", testsFailed);
        $fatal(1, "[TB] aborted");
    end

endmodule

// File: doc/abro_event_scheduler.md
Name: abro_event_scheduler

Overview:
- Shares one ABROStateMachine instance between NUM_REQ event requesters.
- Arbitrates A/B event requests round-robin and issues them as one-cycle pulses on the machine's A/B inputs.
- Watches O. On completion or watchdog timeout, it issues a one-cycle restart (R) pulse, then waits for O to clear before accepting new events.
- Counts completed sequences for status readout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, cycles allowed in COLLECT before a forced restart (>=2).
- CNT_W, 8, width of done_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 asserts).
- req_valid  input  NUM_REQ  per-requester event request.
- req_kind  input  NUM_REQ  per-requester event type: 0=A, 1=B.
- req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- abro_A  output  1  registered A pulse to the ABRO machine.
- abro_B  output  1  registered B pulse to the ABRO machine.
- abro_R  output  1  registered restart pulse to the ABRO machine.
- abro_O  input  1  O output from the ABRO machine.
- done_pulse  output  1  one cycle high per completed sequence.
- timeout_pulse  output  1  one cycle high per watchdog restart.
- done_count  output  CNT_W  saturating count of completions.
- busy  output  1  high whenever state != IDLE.
- state  output  2  current controller state.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state=IDLE; round-robin pointer=0; watchdog=0; done_count=0.
  - Takes effect immediately, mid-pulse included; a pending A/B/R pulse is dropped.
- States (encoding):
  - IDLE=00, COLLECT=01, RESTART=10, CLEAR=11.
- Grants:
  - Only in IDLE or COLLECT, and only when abro_O=0.
  - req_ready is combinational and one-hot: the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - No valid requester -> req_ready all 0.
  - After a grant to index g, the pointer becomes (g+1) mod NUM_REQ. Without a grant the pointer holds.
  - At most one grant per cycle.
- Event pulse timing:
  - A grant in cycle t produces abro_A (kind 0) or abro_B (kind 1) high in cycle t+1 only.
  - The two are never high together.
- IDLE:
  - First grant -> COLLECT; watchdog cleared to 0.
- COLLECT:
  - The watchdog increments every cycle; grants do not clear it.
  - abro_O=1 -> done_pulse=1 next cycle; done_count+1, saturating at all-ones; -> RESTART.
  - Otherwise, watchdog==TIMEOUT-1 -> timeout_pulse=1 next cycle; -> RESTART.
  - O and watchdog expiry in the same cycle: completion wins; no timeout_pulse.
- RESTART:
  - abro_R=1 for exactly this one cycle; no grants; -> CLEAR.
- CLEAR:
  - No grants; stay while abro_O=1; -> IDLE on the first cycle abro_O=0.
- Output timing:
  - done_pulse and timeout_pulse are registered and never both high.
  - busy and state are registered, reflecting the current state.
- Width rules:
  - Watchdog width is clog2(TIMEOUT).
  - done_count wraps never; it saturates.

Decomposition:
- Package abro_sched_pkg:
  - State encodings (IDLE/COLLECT/RESTART/CLEAR).
  - Event kind constants (KIND_A=0, KIND_B=1).
- Sub-module rr_arbiter:
  - Parameterised by NUM_REQ.
  - Inputs: req, pointer, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.
- The scheduler owns the pointer register, FSM, watchdog, pulse registers and counter.

Test Plan:
- Reset release, requester 0 issues A then B (ABRO model asserts O after B):
  - abro_A high one cycle after the first grant, abro_B one cycle after the second.
  - done_pulse=1 once; done_count=1; abro_R one cycle; state returns to 00.
- All 4 requesters hold req_valid=1 continuously in IDLE/COLLECT:
  - Grant order 0,1,2,3,0; exactly one req_ready bit per cycle.
- Requester 2 issues only A, never B, with TIMEOUT=8:
  - timeout_pulse high exactly 8 cycles after entering COLLECT.
  - abro_R follows; done_count unchanged.
- abro_O forced high in the same cycle the watchdog reaches TIMEOUT-1:
  - done_pulse=1, timeout_pulse=0; done_count increments.
- Model holds O high for 3 cycles after R:
  - State stays 11 for 3 cycles; req_ready all 0; IDLE on the cycle after O drops.
- Two further cases:
  - Assert reset mid-COLLECT, one cycle after a grant: abro_A/abro_B/state/busy go 0 immediately; the pointer restarts at 0.
  - With CNT_W=2, 5 completions: done_count reads 1,2,3,3,3.
